// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the chunk-serial add/subtract unit.
//   state_t  : FSM state encoding (IDLE, RUN, DONE)
//   MODE_SUB : mode value selecting a - b
//   MODE_ADD : mode value selecting a + b
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple add/subtract slice.
//   a_s, b_s : operand slices
//   mode     : MODE_SUB (a_s - b_s - cin) or MODE_ADD (a_s + b_s + cin)
//   cin      : chain input (carry-in for add, borrow-in for sub)
//   s        : result slice
//   cout     : chain output (carry-out for add, borrow-out for sub)
module addsub_chunk
   import addsub_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_s,
   input  logic [CHUNK-1:0] b_s,
   input  logic             mode,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_cell
      // Sum/difference bit is identical for both operations; only the
      // chain-out term differs between full adder and full subtractor.
      assign s[i]   = a_s[i] ^ b_s[i] ^ c[i];
      assign c[i+1] = (mode == MODE_ADD)
                    ? ((a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i])))
                    : ((~a_s[i] & b_s[i]) | (~(a_s[i] ^ b_s[i]) & c[i]));
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/multicycle_addsub.sv
// multicycle_addsub: chunk-serial two's-complement add/subtract unit.
// Processes CHUNK bits per cycle over N = WIDTH/CHUNK cycles.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (accept when both high)
//   a, b, mode          : operands, mode 0 = a - b, 1 = a + b
//   out_valid, out_ready: result handshake
//   y                   : result modulo 2^WIDTH
//   cb                  : carry-out (add) / borrow-out (sub)
//   ovf                 : signed overflow of the full-width operation
module multicycle_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cb,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("multicycle_addsub: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             mode_r;
   logic             chain;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] a_s;
   logic [CHUNK-1:0] b_s;
   logic [CHUNK-1:0] s;
   logic             cout;
   logic             ovf_next;

   always_comb begin
      a_s = a_r[int'(idx)*CHUNK +: CHUNK];
      b_s = b_r[int'(idx)*CHUNK +: CHUNK];
   end

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_s  (a_s),
      .b_s  (b_s),
      .mode (mode_r),
      .cin  (chain),
      .s    (s),
      .cout (cout)
   );

   // The result MSB is being written in the same cycle the flags are
   // captured, so overflow looks at the chunk output rather than y.
   always_comb begin
      ovf_next = 1'b0;
      if (mode_r == MODE_ADD)
         ovf_next = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
      else
         ovf_next = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         y         <= '0;
         cb        <= 1'b0;
         ovf       <= 1'b0;
         idx       <= '0;
         chain     <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         mode_r    <= MODE_SUB;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  mode_r   <= mode;
                  idx      <= '0;
                  chain    <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               y[int'(idx)*CHUNK +: CHUNK] <= s;
               chain <= cout;
               idx   <= idx + 1'b1;
               if (idx == IW'(N-1)) begin
                  cb        <= cout;
                  ovf       <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_addsub.sv
// tb_multicycle_addsub: scoreboard bench for multicycle_addsub.
// Main instance WIDTH=16/CHUNK=4 gets directed, backpressure, reset and
// random traffic; three extra instances sweep other WIDTH/CHUNK pairs.
module tb_multicycle_addsub;
   import addsub_pkg::*;

   typedef struct packed {
      logic [15:0] y;
      logic        cb;
      logic        ovf;
      int          acyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst  = 1'b1;
   logic rst0 = 1'b1;
   int   cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int gdone_cnt = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake t=%0t", nm, $time);
   endtask

   task automatic mark_done();
      gdone_cnt++;
   endtask

   // Reference: plain integer arithmetic on w-bit values.
   function automatic exp_t model(input int w, input longint unsigned aa,
                                  input longint unsigned bb, input logic md);
      exp_t e;
      longint unsigned m, r;
      longint sa, sb, sr, lim;
      m   = (longint'(1) << w) - 1;
      aa  = aa & m;
      bb  = bb & m;
      sa  = ((aa >> (w-1)) & 1) != 0 ? longint'(aa) - (longint'(1) << w) : longint'(aa);
      sb  = ((bb >> (w-1)) & 1) != 0 ? longint'(bb) - (longint'(1) << w) : longint'(bb);
      lim = longint'(1) << (w-1);
      if (md == MODE_ADD) begin
         r    = aa + bb;
         e.cb = ((r >> w) & 1) != 0;
         sr   = sa + sb;
      end else begin
         r    = aa - bb;
         e.cb = aa < bb;
         sr   = sa - sb;
      end
      e.y    = 16'(r & m);
      e.ovf  = (sr >= lim) || (sr < -lim);
      e.acyc = 0;
      return e;
   endfunction

   // ---------------- main instance, WIDTH=16 CHUNK=4 ----------------
   logic        in_valid, in_ready, mode, out_valid, out_ready, cb, ovf;
   logic [15:0] a, b, y;
   exp_t        q0[$];
   bit          rnd0 = 1'b0;
   bit          ordy0 = 1'b1;
   logic        ovp0 = 1'b0;

   multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
      .clk(clk), .rst(rst0), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .cb(cb), .ovf(ovf)
   );

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rnd0 ? 1'($urandom) : ordy0;
      end
   end

   always @(negedge clk) begin
      if (!rst0) begin
         if (out_valid && !ovp0) begin
            if (q0.size() == 0) chk("u0_spurious_valid", 1, 0);
            else                chk("u0_latency", cyc - q0[0].acyc, 4);
         end
         if (out_valid && out_ready) begin
            if (q0.size() == 0) chk("u0_spurious_result", 1, 0);
            else begin
               exp_t e;
               e = q0.pop_front();
               chk("u0_y", y, e.y);
               chk("u0_cb", cb, e.cb);
               chk("u0_ovf", ovf, e.ovf);
            end
         end
      end
      ovp0 <= out_valid;
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue0(input logic [15:0] aa, input logic [15:0] bb,
                         input logic md, input exp_t e);
      int n = 0;
      a = aa; b = bb; mode = md; in_valid = 1'b1;
      while (!in_ready) begin
         @(posedge clk); #1;
         n++;
         if (n > 200) begin
            timeout_fail("u0_accept");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.acyc = cyc;
      q0.push_back(e);
   endtask

   task automatic drain0();
      int n = 0;
      while ((q0.size() != 0) || !in_ready) begin
         @(posedge clk); #1;
         n++;
         if (n > 300) begin
            timeout_fail("u0_drain");
            return;
         end
      end
   endtask

   // ---------------- parametric sweep instances ----------------
   localparam int GW[3] = '{16, 16, 10};
   localparam int GC[3] = '{16, 1, 5};

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int W = GW[gi];
      localparam int C = GC[gi];
      localparam int N = W / C;

      logic         iv, ir, md, ov, ordy, gcb, govf;
      logic [W-1:0] ga, gb, gy;
      exp_t         q[$];
      logic         ovp = 1'b0;

      multicycle_addsub #(.WIDTH(W), .CHUNK(C)) dut (
         .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
         .a(ga), .b(gb), .mode(md), .out_valid(ov), .out_ready(ordy),
         .y(gy), .cb(gcb), .ovf(govf)
      );

      initial begin
         ordy = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            ordy = 1'($urandom);
         end
      end

      always @(negedge clk) begin
         if (!rst) begin
            if (ov && !ovp) begin
               if (q.size() == 0) chk($sformatf("g%0d_spurious_valid", gi), 1, 0);
               else               chk($sformatf("g%0d_latency", gi), cyc - q[0].acyc, N);
            end
            if (ov && ordy) begin
               if (q.size() == 0) chk($sformatf("g%0d_spurious_result", gi), 1, 0);
               else begin
                  exp_t e;
                  e = q.pop_front();
                  chk($sformatf("g%0d_y", gi), gy, e.y);
                  chk($sformatf("g%0d_cb", gi), gcb, e.cb);
                  chk($sformatf("g%0d_ovf", gi), govf, e.ovf);
               end
            end
         end
         ovp <= ov;
      end

      initial begin
         exp_t e;
         int   n;
         iv = 1'b0; ga = '0; gb = '0; md = 1'b0;
         while (rst) @(posedge clk);
         @(posedge clk); #1;
         for (int i = 0; i < 30; i++) begin
            ga = W'($urandom);
            gb = W'($urandom);
            md = 1'($urandom);
            e  = model(W, longint'(ga), longint'(gb), md);
            iv = 1'b1;
            n  = 0;
            while (!ir && (n <= 200)) begin
               @(posedge clk); #1;
               n++;
            end
            if (n > 200) timeout_fail($sformatf("g%0d_accept", gi));
            else begin
               @(posedge clk); #1;
               e.acyc = cyc;
               q.push_back(e);
            end
            iv = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         n = 0;
         while ((q.size() != 0) && (n < 500)) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("g%0d_drain", gi), q.size(), 0);
         mark_done();
      end
   end

   // ---------------- main sequence ----------------
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        md;
      logic [15:0] y;
      logic        cb;
      logic        ovf;
   } vec_t;

   vec_t dir[5] = '{
      '{16'd1000,  16'd499, MODE_SUB, 16'd501,   1'b0, 1'b0},
      '{16'd5,     16'd9,   MODE_SUB, 16'hFFFC,  1'b1, 1'b0},
      '{16'h8000,  16'd1,   MODE_SUB, 16'h7FFF,  1'b0, 1'b1},
      '{16'h7FFF,  16'd1,   MODE_ADD, 16'h8000,  1'b0, 1'b1},
      '{16'hFFFF,  16'd1,   MODE_ADD, 16'h0000,  1'b1, 1'b0}
   };

   initial begin
      exp_t e;
      int   n;
      in_valid = 1'b0; a = '0; b = '0; mode = MODE_SUB;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; rst0 = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_cb", cb, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk); #1;

      // Directed vectors with fixed expected values.
      foreach (dir[i]) begin
         e = '{y: dir[i].y, cb: dir[i].cb, ovf: dir[i].ovf, acyc: 0};
         issue0(dir[i].a, dir[i].b, dir[i].md, e);
      end
      drain0();

      // Backpressure: result must hold and new operands must be ignored.
      ordy0 = 1'b0;
      @(posedge clk); #1;
      e = model(16, 64'd1234, 64'd4321, MODE_SUB);
      issue0(16'd1234, 16'd4321, MODE_SUB, e);
      n = 0;
      while (!out_valid && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeout_fail("bp_valid");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         in_valid = (i % 2 == 0);
         a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold", {y, cb, ovf}, {e.y, e.cb, e.ovf});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      ordy0 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_ready) && (n < 20));
      if (!(out_valid && out_ready)) timeout_fail("bp_release");
      @(posedge clk); #1;
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      @(negedge clk);
      chk("bp_no_extra_accept", out_valid, 0);
      @(posedge clk); #1;

      // Reset during the second RUN cycle discards the operation.
      e = model(16, 64'd4000, 64'd17, MODE_ADD);
      issue0(16'd4000, 16'd17, MODE_ADD, e);
      @(posedge clk); #1;
      rst0 = 1'b1;
      q0.delete();
      @(posedge clk); #1;
      rst0 = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_y", y, 0);
      @(posedge clk); #1;
      e = '{y: 16'd200, cb: 1'b0, ovf: 1'b0, acyc: 0};
      issue0(16'd300, 16'd100, MODE_SUB, e);
      drain0();

      // Random traffic with randomised out_ready.
      rnd0 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         logic [15:0] ra, rb;
         logic        rm;
         ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
         if (i % 8 == 0) rb = ra;
         e = model(16, longint'(ra), longint'(rb), rm);
         issue0(ra, rb, rm, e);
      end
      rnd0 = 1'b0;
      ordy0 = 1'b1;
      drain0();

      n = 0;
      while ((gdone_cnt < 3) && (n < 20000)) begin
         @(posedge clk);
         n++;
      end
      if (gdone_cnt < 3) timeout_fail("sweep_done");
      chk("u0_queue_empty", q0.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
